// File: rtl/alu_share_ctrl.sv
// Round-robin scheduler sharing one 32-bit ALU between two requesters.
// Returns a tagged result plus {V,C,Z,N} flags on a valid/ready response channel.
module alu_share_ctrl #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,

  input  logic              req1_valid,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              busy
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned FLAG_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                id_q, id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic [FLAG_W-1:0]   rsp_flags_q, rsp_flags_d;

  logic                grant_c;
  logic                accept_c;
  logic [DATA_W-1:0]   b_eff_c;
  logic [DATA_W:0]     sum_c;
  logic [DATA_W-1:0]   alu_result_c;
  logic [FLAG_W-1:0]   alu_flags_c;
  logic                flag_v_c;
  logic                flag_c_c;

  // Single valid requester wins; on contention the one not granted last time wins.
  always_comb begin
    grant_c = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_c = ~last_grant_q;
    end else if (req1_valid) begin
      grant_c = 1'b1;
    end
  end

  assign accept_c   = (state_q == ST_IDLE) & ~rst & (req0_valid | req1_valid);
  assign req0_ready = accept_c & ~grant_c;
  assign req1_ready = accept_c &  grant_c;

  // Shared adder: op[0] selects subtract via a + ~b + 1.
  assign b_eff_c = op_q[0] ? ~b_q : b_q;
  assign sum_c   = {1'b0, a_q} + {1'b0, b_eff_c} + (DATA_W+1)'(op_q[0]);

  always_comb begin
    alu_result_c = '0;
    case (op_q)
      3'b000:  alu_result_c = sum_c[DATA_W-1:0];
      3'b001:  alu_result_c = sum_c[DATA_W-1:0];
      3'b010:  alu_result_c = a_q & b_q;
      3'b011:  alu_result_c = a_q | b_q;
      // SLT takes the raw sum sign, intentionally without overflow correction
      3'b101:  alu_result_c = DATA_W'(sum_c[DATA_W-1]);
      default: alu_result_c = '0;
    endcase
  end

  assign flag_v_c    = (sum_c[DATA_W-1] ^ a_q[DATA_W-1])
                     & ~(op_q[0] ^ b_q[DATA_W-1] ^ a_q[DATA_W-1])
                     & ~op_q[1];
  assign flag_c_c    = ~op_q[1] & sum_c[DATA_W];
  assign alu_flags_c = {flag_v_c, flag_c_c, (alu_result_c == '0), alu_result_c[DATA_W-1]};

  // Next-state and register update logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          last_grant_d = grant_c;
          id_d         = grant_c;
          op_d         = grant_c ? req1_op : req0_op;
          a_d          = grant_c ? req1_a  : req0_a;
          b_d          = grant_c ? req1_b  : req0_b;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_valid_d  = 1'b1;
        rsp_id_d     = id_q;
        rsp_result_d = alu_result_c;
        rsp_flags_d  = alu_flags_c;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed cases, random single ops,
// contention, backpressure and reset-in-flight against an arithmetic reference.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  logic [2:0]  p_op [2];
  logic [31:0] p_a  [2];
  logic [31:0] p_b  [2];

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic [3:0]  fl;
    int          cyc;
  } exp_t;

  alu_share_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference ALU from signed/unsigned integer arithmetic.
  function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic [3:0] fl);
    longint sa, sb, ua, ub, s;
    logic [31:0] wrap;
    logic v, c;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    s  = op[0] ? (sa - sb) : (sa + sb);
    wrap = 32'(s);
    v = !op[1] && ((s > 64'sh7FFFFFFF) || (s < -64'sh80000000));
    c = !op[1] && (op[0] ? (ua >= ub) : ((ua + ub) > 64'shFFFFFFFF));
    case (op)
      3'd0, 3'd1: res = wrap;
      3'd2:       res = a & b;
      3'd3:       res = a | b;
      3'd5:       res = {31'd0, wrap[31]};
      default:    res = 32'd0;
    endcase
    fl = {v, c, (res == 32'd0), res[31]};
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic put(input int rid);
    if (rid == 0) begin
      req0_op = p_op[0]; req0_a = p_a[0]; req0_b = p_b[0];
    end else begin
      req1_op = p_op[1]; req1_a = p_a[1]; req1_b = p_b[1];
    end
  endtask

  task automatic new_payload(input int rid);
    p_op[rid] = 3'($urandom_range(0, 7));
    p_a[rid]  = rnd_val();
    p_b[rid]  = rnd_val();
    put(rid);
  endtask

  // Single uncontended op; entered and left at a drive point with the block idle.
  task automatic do_op(input int rid, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag, output logic [31:0] r, output logic [3:0] f);
    logic [31:0] er;
    logic [3:0]  ef;
    ref_alu(op, a, b, er, ef);
    p_op[rid] = op; p_a[rid] = a; p_b[rid] = b;
    put(rid);
    req0_valid = (rid == 0);
    req1_valid = (rid == 1);
    @(negedge clk);
    check({tag, "_rdy"}, {req1_ready, req0_ready}, (rid == 0) ? 2'b01 : 2'b10);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check({tag, "_exec"}, {rsp_valid, busy, req1_ready, req0_ready}, 4'b0100);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_vld_id"}, {rsp_valid, rsp_id}, {1'b1, 1'(rid)});
    check({tag, "_res"}, rsp_result, er);
    check({tag, "_fl"}, rsp_flags, ef);
    r = rsp_result;
    f = rsp_flags;
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_idle"}, {rsp_valid, busy}, 2'b00);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r, er;
    logic [3:0]  f, ef;
    exp_t        q[$];
    exp_t        e;
    int          last_acc, n_acc, exp_next, refresh, bp_id;
    bit          got;

    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin p_op[i] = '0; p_a[i] = '0; p_b[i] = '0; put(i); end

    // Reset values; a valid request during reset must not see ready
    repeat (2) @(posedge clk);
    #1 req0_valid = 1'b1;
    @(negedge clk);
    check("rst_state", {rsp_valid, busy, rsp_id}, 3'b000);
    check("rst_res", rsp_result, 32'd0);
    check("rst_fl", rsp_flags, 4'd0);
    check("rst_rdy", {req1_ready, req0_ready}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0;

    do_op(0, 3'b000, 32'h7FFF_FFFF, 32'd1, "add", r, f);
    check("add_res_k", r, 32'h8000_0000);
    check("add_fl_k", f, 4'b1001);
    do_op(1, 3'b001, 32'd5, 32'd5, "sub", r, f);
    check("sub_res_k", r, 32'd0);
    check("sub_fl_k", f, 4'b0110);
    do_op(0, 3'b101, 32'd3, 32'd7, "slt", r, f);
    check("slt_res_k", r, 32'd1);
    check("slt_fl_k", f, 4'b0000);
    do_op(1, 3'b110, 32'hFFFF_FFFF, 32'd1, "op6", r, f);
    check("op6_res_k", r, 32'd0);
    check("op6_fl_k", f, 4'b0010);

    for (int i = 0; i < 40; i++) begin
      do_op(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rnd_val(), rnd_val(), "rnd", r, f);
    end

    // Contention straight out of reset: strict alternation starting with requester 0
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    new_payload(0); new_payload(1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    last_acc = -1; n_acc = 0; exp_next = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      refresh = -1;
      @(negedge clk);
      if (rsp_valid) begin
        if (q.size() == 0) check("cont_extra_rsp", 1'b1, 1'b0);
        else begin
          e = q.pop_front();
          check("cont_id", rsp_id, e.id);
          check("cont_res", rsp_result, e.res);
          check("cont_fl", rsp_flags, e.fl);
          check("cont_lat", 64'(cyc - e.cyc), 64'd2);
        end
      end
      if (req0_ready || req1_ready) begin
        check("cont_grant", {req1_ready, req0_ready}, (exp_next == 0) ? 2'b01 : 2'b10);
        if (last_acc >= 0) check("cont_space", 64'(cyc - last_acc), 64'd3);
        ref_alu(p_op[exp_next], p_a[exp_next], p_b[exp_next], er, ef);
        e.id = 1'(exp_next); e.res = er; e.fl = ef; e.cyc = cyc;
        q.push_back(e);
        last_acc = cyc; n_acc++;
        refresh = exp_next;
        exp_next ^= 1;
      end
      @(posedge clk); #1;
      if (refresh >= 0) new_payload(refresh);
    end
    check("cont_n_acc", 64'(n_acc), 64'd10);
    check("cont_q_empty", 64'(q.size()), 64'd0);

    // Backpressure with both requesters still valid
    rsp_ready = 1'b0;
    got = 1'b0;
    bp_id = exp_next;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("bp_accept", got, 1'b1);
    check("bp_grant", {req1_ready, req0_ready}, (bp_id == 0) ? 2'b01 : 2'b10);
    ref_alu(p_op[bp_id], p_a[bp_id], p_b[bp_id], er, ef);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("bp_hold", {rsp_valid, busy, req1_ready, req0_ready}, 4'b1100);
      check("bp_hold_payload", {rsp_id, rsp_flags, rsp_result}, {1'(bp_id), ef, er});
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {rsp_valid, req1_ready, req0_ready}, 3'b100);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_after", {rsp_valid, busy}, 2'b00);
    check("bp_next_grant", {req1_ready, req0_ready}, (bp_id == 0) ? 2'b10 : 2'b01);

    // Reset while a response is held; afterwards requester 0 wins contention
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("rmid_resp", {rsp_valid, busy}, 2'b11);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rmid_rst_rdy", {req1_ready, req0_ready}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rmid_after", {rsp_valid, busy}, 2'b00);
    check("rmid_grant", {req1_ready, req0_ready}, 2'b01);

    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
